// File: rtl/fir_pkg.sv
// Shared definitions for the sequential FIR controller: FSM states,
// output saturation limits and the rounding bias helper.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_TAPS,
    ST_DRAIN,
    ST_OUT
  } fir_state_t;

  localparam logic signed [15:0] Y_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Y_MIN = 16'sh8000;

  // Half an LSB of the output, preloaded into the accumulator so the final shift rounds.
  function automatic logic [31:0] round_bias(input int unsigned frac);
    return (frac == 0) ? '0 : (32'd1 << (frac - 1));
  endfunction

endpackage

// File: rtl/fir_ring_buf.sv
// Sample delay line: one synchronous write port, one asynchronous read port,
// addresses always kept in 0..DEPTH-1 by the caller.
module fir_ring_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR controller: steps one sample through NTAPS taps of an
// external multiply-accumulate block, then rounds, shifts and saturates.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS   = 16,
  parameter int unsigned FRAC    = 15,
  parameter int unsigned MAC_LAT = 2,
  localparam int unsigned AW     = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic signed [15:0] SAMPLE_IN,
  input  logic               SAMPLE_VALID,
  output logic               SAMPLE_READY,
  output logic [AW-1:0]      COEF_ADDR,
  input  logic signed [15:0] COEF_DATA,
  output logic signed [15:0] MULT_A,
  output logic signed [15:0] MULT_B,
  output logic               MAC_LDA,
  output logic               MAC_ENA,
  output logic               MAC_ADDSUB,
  output logic [31:0]        MAC_DIRECT,
  input  logic signed [31:0] MAC_O,
  output logic signed [15:0] Y,
  output logic               Y_VALID,
  input  logic               Y_READY
);

  localparam logic signed [31:0] SAT_HI = 32'(Y_MAX);
  localparam logic signed [31:0] SAT_LO = 32'(Y_MIN);

  fir_state_t         r_state, w_next;
  logic [7:0]         r_cnt;
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [AW-1:0]      w_wptr_inc, w_rptr_dec;
  logic signed [15:0] r_opa, r_y;
  logic [15:0]        w_rd_data;
  logic               r_rst_q;
  logic               w_accept, w_taps_last, w_drain_last;
  logic signed [31:0] w_shift;
  logic signed [15:0] w_sat;

  assign w_accept     = SAMPLE_READY && SAMPLE_VALID;
  assign w_taps_last  = (r_cnt == 8'(NTAPS - 1));
  assign w_drain_last = (r_cnt == 8'(MAC_LAT - 1));
  assign w_wptr_inc   = (r_wptr == AW'(NTAPS - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_dec   = (r_rptr == '0) ? AW'(NTAPS - 1) : r_rptr - 1'b1;

  assign w_shift = MAC_O >>> FRAC;
  assign w_sat   = (w_shift > SAT_HI) ? Y_MAX :
                   (w_shift < SAT_LO) ? Y_MIN : w_shift[15:0];

  fir_ring_buf #(
    .DEPTH (NTAPS),
    .AW    (AW),
    .DW    (16)
  ) u_ring (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_we    (w_accept),
    .i_waddr (r_wptr),
    .i_wdata (SAMPLE_IN),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_CLR;
      ST_CLR:   w_next = ST_TAPS;
      ST_TAPS:  if (w_taps_last) w_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_last) w_next = ST_OUT;
      ST_OUT:   if (Y_READY) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // The read pointer runs one cycle ahead of the tap so r_opa lines up with
  // the registered coefficient returned for the previous COEF_ADDR.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_opa   <= '0;
      r_y     <= '0;
      r_rst_q <= 1'b1;
    end else begin
      r_rst_q <= 1'b0;
      r_opa   <= w_rd_data;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state == ST_TAPS || r_state == ST_DRAIN) r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_wptr <= w_wptr_inc;
        r_rptr <= r_wptr;
      end else if (r_state == ST_CLR || r_state == ST_TAPS) begin
        r_rptr <= w_rptr_dec;
      end
      if (r_state == ST_DRAIN && w_drain_last) r_y <= w_sat;
    end
  end

  always_comb begin
    SAMPLE_READY = 1'b0;
    COEF_ADDR    = '0;
    MULT_A       = '0;
    MULT_B       = '0;
    MAC_LDA      = 1'b0;
    MAC_ENA      = 1'b0;
    MAC_ADDSUB   = 1'b0;
    MAC_DIRECT   = '0;
    Y_VALID      = 1'b0;
    unique case (r_state)
      ST_IDLE: SAMPLE_READY = !r_rst_q;
      ST_CLR: begin
        MAC_LDA    = 1'b1;
        MAC_ENA    = 1'b1;
        MAC_DIRECT = round_bias(FRAC);
      end
      ST_TAPS: begin
        MAC_ENA   = 1'b1;
        MULT_A    = r_opa;
        MULT_B    = COEF_DATA;
        COEF_ADDR = w_taps_last ? '0 : AW'(r_cnt + 8'd1);
      end
      ST_OUT:  Y_VALID = 1'b1;
      default: ;
    endcase
  end

  assign Y = r_y;

endmodule
